rf_drsw_seq: RTL and testbench

RF_DRSW_SEQ -- requirements
Module: rf_drsw_seq

---
 rtl/rf_pkg.sv | 21 ++
 rtl/rf_spram.sv | 21 ++
 rtl/rf_drsw_seq.sv | 127 ++++++++++++
 tb/tb_rf_drsw_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types for the sequential dual-read single-write register file.
// Address width follows the embedded (16-reg) or full (32-reg) variant.
package rf_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    RD1,
    RD2,
    DONE
  } rf_state_t;

  localparam int XLEN    = 32;
  localparam int AW_EMB  = 4;
  localparam int AW_FULL = 5;

  function automatic int aw_f(input bit embedded);
    return embedded ? AW_EMB : AW_FULL;
  endfunction

endpackage

// File: rtl/rf_spram.sv
// Single-port synchronous RAM: one access per cycle,
// read data appears the cycle after the address.
module rf_spram #(
  parameter int depth = 16,
  parameter int width = 32
) (
  input  logic                     Clk,
  input  logic                     We,
  input  logic [$clog2(depth)-1:0] Addr,
  input  logic [width-1:0]         WData,
  output logic [width-1:0]         RData
);

  logic [width-1:0] mem_q [depth];

  always_ff @(posedge Clk) begin
    if (We) mem_q[Addr] <= WData;
    RData <= mem_q[Addr];
  end

endmodule

// File: rtl/rf_drsw_seq.sv
// Register file with two read ports time-multiplexed onto one
// single-port RAM; reads take three cycles, writes one.
module rf_drsw_seq
  import rf_pkg::*;
#(
  parameter bit  embedded = 1'b1,
  localparam int AW       = aw_f(embedded)
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            ReadReq,
  input  logic [AW-1:0]   Rs1Addr,
  input  logic [AW-1:0]   Rs2Addr,
  output logic            ReadAck,
  output logic            ReadValid,
  output logic [XLEN-1:0] Rs1Data,
  output logic [XLEN-1:0] Rs2Data,
  input  logic            WriteReq,
  input  logic [AW-1:0]   RdAddr,
  input  logic [XLEN-1:0] RdData,
  output logic            WriteAck,
  output logic            Busy
);

  localparam int            DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  rf_state_t       state_q;
  logic [AW-1:0]   clr_q;
  logic [AW-1:0]   rs1_q;
  logic [AW-1:0]   rs2_q;
  logic [XLEN-1:0] tmp_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic            valid_q;

  logic            ram_we;
  logic [AW-1:0]   ram_addr;
  logic [XLEN-1:0] ram_wd;
  logic [XLEN-1:0] ram_rd;
  logic            idle;

  assign idle      = (state_q == IDLE) && !Rst;
  assign WriteAck  = idle && WriteReq;
  assign ReadAck   = idle && ReadReq && !WriteReq;
  assign Busy      = Rst || (state_q != IDLE);
  assign ReadValid = valid_q;
  assign Rs1Data   = rs1_data_q;
  assign Rs2Data   = rs2_data_q;

  // Single RAM port arbitration: clear, write, or read address.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_wd   = '0;
    unique case (state_q)
      CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = clr_q;
      end
      IDLE: begin
        if (WriteReq) begin
          ram_we   = (RdAddr != '0);
          ram_addr = RdAddr;
          ram_wd   = RdData;
        end else begin
          ram_addr = Rs1Addr;
        end
      end
      RD1:     ram_addr = rs2_q;
      default: ram_addr = '0;
    endcase
    if (Rst) ram_we = 1'b0;
  end

  rf_spram #(
    .depth(DEPTH),
    .width(XLEN)
  ) u_ram (
    .Clk  (Clk),
    .We   (ram_we),
    .Addr (ram_addr),
    .WData(ram_wd),
    .RData(ram_rd)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= CLEAR;
      clr_q      <= AW'(1);
      rs1_q      <= '0;
      rs2_q      <= '0;
      tmp_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        CLEAR: begin
          clr_q <= clr_q + AW'(1);
          if (clr_q == LAST) state_q <= IDLE;
        end
        IDLE: begin
          if (ReadAck) begin
            rs1_q   <= Rs1Addr;
            rs2_q   <= Rs2Addr;
            state_q <= RD1;
          end
        end
        RD1: begin
          tmp_q   <= (rs1_q == '0) ? '0 : ram_rd;
          state_q <= RD2;
        end
        RD2: begin
          rs1_data_q <= tmp_q;
          rs2_data_q <= (rs2_q == '0) ? '0 : ram_rd;
          valid_q    <= 1'b1;
          state_q    <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_drsw_seq.sv
// Runs the 16-entry and 32-entry variants in lockstep on shared
// stimulus, each against an array model of the register file.
module tb_rf_drsw_seq;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        ReadReq = 1'b0;
  logic        WriteReq = 1'b0;
  logic [4:0]  Rs1A = '0;
  logic [4:0]  Rs2A = '0;
  logic [4:0]  RdA = '0;
  logic [31:0] RdD = '0;

  logic        a_rack, a_rv, a_wack, a_busy;
  logic [31:0] a_d1, a_d2;
  logic        b_rack, b_rv, b_wack, b_busy;
  logic [31:0] b_d1, b_d2;

  rf_drsw_seq #(.embedded(1'b1)) dut16 (
    .Clk(Clk), .Rst(Rst),
    .ReadReq(ReadReq), .Rs1Addr(Rs1A[3:0]), .Rs2Addr(Rs2A[3:0]),
    .ReadAck(a_rack), .ReadValid(a_rv),
    .Rs1Data(a_d1), .Rs2Data(a_d2),
    .WriteReq(WriteReq), .RdAddr(RdA[3:0]), .RdData(RdD),
    .WriteAck(a_wack), .Busy(a_busy)
  );

  rf_drsw_seq #(.embedded(1'b0)) dut32 (
    .Clk(Clk), .Rst(Rst),
    .ReadReq(ReadReq), .Rs1Addr(Rs1A), .Rs2Addr(Rs2A),
    .ReadAck(b_rack), .ReadValid(b_rv),
    .Rs1Data(b_d1), .Rs2Data(b_d2),
    .WriteReq(WriteReq), .RdAddr(RdA), .RdData(RdD),
    .WriteAck(b_wack), .Busy(b_busy)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int passed = 0;
  logic [31:0] m16 [16];
  logic [31:0] m32 [32];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_write(input logic [4:0] a, input logic [31:0] d);
    if (a[3:0] != 4'd0) m16[a[3:0]] = d;
    if (a != 5'd0) m32[a] = d;
  endtask

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    int n16, n32;
    logic rv;
    Rst = 1'b1;
    ReadReq = 1'b0;
    WriteReq = 1'b0;
    tick();
    Rst = 1'b0;
    #1;
    chk({tag, "_busy"}, 32'({a_busy, b_busy}), 32'd3);
    chk({tag, "_rv"}, 32'({a_rv, b_rv}), 32'd0);
    chk({tag, "_d16"}, a_d1 | a_d2, 32'd0);
    chk({tag, "_d32"}, b_d1 | b_d2, 32'd0);
    n16 = 0;
    n32 = 0;
    rv = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (!a_busy && !b_busy) break;
      if (a_busy) n16++;
      if (b_busy) n32++;
      if (a_rv || b_rv) rv = 1'b1;
      tick();
    end
    chk({tag, "_clr16"}, 32'(n16), 32'd15);
    chk({tag, "_clr32"}, 32'(n32), 32'd31);
    chk({tag, "_clr_rv"}, 32'(rv), 32'd0);
    foreach (m16[i]) m16[i] = '0;
    foreach (m32[i]) m32[i] = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    WriteReq = 1'b1;
    RdA = a;
    RdD = d;
    #1;
    chk("wr_ack", 32'({a_wack, b_wack}), 32'd3);
    model_write(a, d);
    tick();
    WriteReq = 1'b0;
  endtask

  task automatic rd(input logic [4:0] r1, input logic [4:0] r2,
                    input bit late, input logic [4:0] wa,
                    input logic [31:0] wd);
    logic [31:0] x1a, x2a, x1b, x2b;
    int lat;
    ReadReq = 1'b1;
    Rs1A = r1;
    Rs2A = r2;
    #1;
    chk("rd_ack", 32'({a_rack, b_rack}), 32'd3);
    x1a = m16[r1[3:0]];
    x2a = m16[r2[3:0]];
    x1b = m32[r1];
    x2b = m32[r2];
    tick();
    ReadReq = 1'b0;
    Rs1A = 5'($urandom);
    Rs2A = 5'($urandom);
    if (late) begin
      WriteReq = 1'b1;
      RdA = wa;
      RdD = wd;
    end
    #1;
    lat = 1;
    while (!(a_rv || b_rv) && lat < 8) begin
      if (late) chk("late_wack_low", 32'({a_wack, b_wack}), 32'd0);
      tick();
      lat++;
    end
    chk("rd_lat", 32'(lat), 32'd3);
    chk("rd_rv", 32'({a_rv, b_rv}), 32'd3);
    chk("rd16_rs1", a_d1, x1a);
    chk("rd16_rs2", a_d2, x2a);
    chk("rd32_rs1", b_d1, x1b);
    chk("rd32_rs2", b_d2, x2b);
    if (late) chk("done_wack_low", 32'({a_wack, b_wack}), 32'd0);
    tick();
    chk("rv_pulse", 32'({a_rv, b_rv}), 32'd0);
    chk("hold16", a_d1 ^ a_d2, x1a ^ x2a);
    chk("hold32", b_d1 ^ b_d2, x1b ^ x2b);
    chk("idle_busy", 32'({a_busy, b_busy}), 32'd0);
    if (late) begin
      chk("late_wack", 32'({a_wack, b_wack}), 32'd3);
      model_write(wa, wd);
      tick();
      WriteReq = 1'b0;
    end
  endtask

  task automatic rdwr_same(input logic [4:0] a, input logic [31:0] d,
                           input logic [4:0] r2);
    WriteReq = 1'b1;
    RdA = a;
    RdD = d;
    ReadReq = 1'b1;
    Rs1A = a;
    Rs2A = r2;
    #1;
    chk("prio_wack", 32'({a_wack, b_wack}), 32'd3);
    chk("prio_rack", 32'({a_rack, b_rack}), 32'd0);
    model_write(a, d);
    tick();
    WriteReq = 1'b0;
    rd(a, r2, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    do_reset("por");
    rd(5'd5, 5'd9, 1'b0, 5'd0, 32'd0);

    wr(5'd3, 32'hDEADBEEF);
    rd(5'd3, 5'd0, 1'b0, 5'd0, 32'd0);

    rdwr_same(5'd7, 32'h12345678, 5'd7);

    wr(5'd4, 32'h11111111);
    rd(5'd4, 5'd3, 1'b1, 5'd4, 32'h22222222);
    rd(5'd4, 5'd4, 1'b0, 5'd0, 32'd0);

    wr(5'd0, 32'hFFFFFFFF);
    rd(5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    wr(5'd31, 32'hA5A5A5A5);
    rd(5'd31, 5'd15, 1'b0, 5'd0, 32'd0);
    wr(5'd16, 32'h0BADF00D);
    rd(5'd16, 5'd0, 1'b0, 5'd0, 32'd0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: wr(5'($urandom), $urandom);
        1: rd(5'($urandom), 5'($urandom), 1'b0, 5'd0, 32'd0);
        2: rdwr_same(5'($urandom), $urandom, 5'($urandom));
        default: rd(5'($urandom), 5'($urandom), 1'b1,
                    5'($urandom), $urandom);
      endcase
    end

    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    repeat (6) tick();
    do_reset("midclr");

    wr(5'd3, 32'hCAFEF00D);
    wr(5'd20, 32'h87654321);
    ReadReq = 1'b1;
    Rs1A = 5'd3;
    Rs2A = 5'd20;
    #1;
    chk("rd2_ack", 32'({a_rack, b_rack}), 32'd3);
    tick();
    ReadReq = 1'b0;
    tick();
    do_reset("rd2rst");
    rd(5'd3, 5'd20, 1'b0, 5'd0, 32'd0);
    rd(5'd4, 5'd7, 1'b0, 5'd0, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
